commu_push: RTL and testbench

- Payload stage of the slot transmit sequence.
- On a one-cycle fire_push strobe from the communication main FSM, it reads len_push bytes from the frame buffer RAM from address 0 upward.
- It hands each byte to the byte transmitter through a valid/ready handshake, then returns a one-cycle done_push pulse.
- It sits between the main FSM and the transmit serializer, alongside the head and tail stages.

---
 rtl/commu_push.sv | 151 +++++++++++++++
 tb/tb_commu_push.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commu_push.sv
// rtl/commu_push.sv - payload stage of the slot transmit sequence
//
// Purpose: on a fire_push strobe, reads len_push bytes from the frame buffer
// RAM starting at address 0, hands each one to the byte transmitter over a
// valid/ready handshake, then pulses done_push for one cycle.
//
// Optional feature macro: PUSH_CSUM_EN
//   When defined, an 8-bit XOR of the sent payload bytes is appended as one
//   extra byte after the payload. A zero-length transfer then sends 0x00.
//
// Ports:
//   clk_sys      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   fire_push    in   one-cycle start strobe, honoured only when idle
//   done_push    out  one-cycle completion pulse
//   len_push     in   payload byte count, saturated to 2**ADDR_W
//   buf_rd_en    out  frame buffer read enable
//   buf_rd_addr  out  frame buffer read address
//   buf_rd_data  in   frame buffer read data, valid the cycle after buf_rd_en
//   tx_data      out  byte to the transmitter
//   tx_vld       out  tx_data is valid
//   tx_rdy       in   transmitter accepts when tx_vld and tx_rdy are high

module commu_push #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              fire_push,
    output logic              done_push,
    input  logic [ADDR_W:0]   len_push,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [7:0]        buf_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_vld,
    input  logic              tx_rdy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
`ifdef PUSH_CSUM_EN
    localparam logic [2:0] S_CSUM = 3'd4;
`endif
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W:0]   len_lat;
    logic              last;
`ifdef PUSH_CSUM_EN
    logic [7:0]        csum;
`endif

    // len_lat is at least 1 whenever this is consulted (S_SEND is only
    // reachable with a nonzero length), so the subtraction cannot underflow.
    assign last = ({1'b0, cnt} == (len_lat - 1'b1));

    // Control outputs are pure state decodes so no input reaches an output
    // combinationally, and reset clears them the instant rst_n falls.
    assign buf_rd_en = (state == S_READ);
    assign done_push = (state == S_DONE);
`ifdef PUSH_CSUM_EN
    assign tx_vld    = (state == S_SEND) || (state == S_CSUM);
`else
    assign tx_vld    = (state == S_SEND);
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            len_lat     <= '0;
            buf_rd_addr <= '0;
            tx_data     <= 8'h00;
`ifdef PUSH_CSUM_EN
            csum        <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cnt         <= '0;
                    buf_rd_addr <= '0;
                    if (fire_push) begin
                        len_lat <= (len_push > LEN_MAX) ? LEN_MAX : len_push;
`ifdef PUSH_CSUM_EN
                        csum    <= 8'h00;
`endif
                        if (len_push != '0) begin
                            state <= S_READ;
                        end else begin
`ifdef PUSH_CSUM_EN
                            // Empty payload: the checksum byte alone is 0x00.
                            tx_data <= 8'h00;
                            state   <= S_CSUM;
`else
                            state   <= S_DONE;
`endif
                        end
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    tx_data <= buf_rd_data;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (tx_rdy) begin
`ifdef PUSH_CSUM_EN
                        csum <= csum ^ tx_data;
`endif
                        if (last) begin
`ifdef PUSH_CSUM_EN
                            // Fold in the byte just accepted so the final
                            // checksum is ready to present next cycle.
                            tx_data <= csum ^ tx_data;
                            state   <= S_CSUM;
`else
                            state   <= S_DONE;
`endif
                        end else begin
                            cnt         <= cnt + 1'b1;
                            buf_rd_addr <= buf_rd_addr + 1'b1;
                            state       <= S_READ;
                        end
                    end
                end
`ifdef PUSH_CSUM_EN
                S_CSUM: begin
                    if (tx_rdy) begin
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commu_push.sv
// tb/tb_commu_push.sv - directed self-checking bench for commu_push
module tb_commu_push;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef PUSH_CSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic              clk_sys     = 1'b0;
    logic              rst_n       = 1'b0;
    logic              fire_push   = 1'b0;
    logic [ADDR_W:0]   len_push    = '0;
    logic              tx_rdy      = 1'b0;
    logic [7:0]        buf_rd_data = 8'h00;
    logic              done_push;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [7:0]        tx_data;
    logic              tx_vld;

    logic [7:0] mem [DEPTH];

    int errors = 0;
    int checks = 0;

    logic [7:0] sent_q [$];
    int         rd_q   [$];
    int         done_cnt   = 0;
    int         stall_bad  = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    commu_push #(.ADDR_W(ADDR_W)) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .fire_push   (fire_push),
        .done_push   (done_push),
        .len_push    (len_push),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .tx_data     (tx_data),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    // Inputs change only just after a rising edge, so what is seen here is
    // exactly what the next rising edge will act on.
    always @(negedge clk_sys) begin
        if (tx_vld && tx_rdy) sent_q.push_back(tx_data);
        if (buf_rd_en) rd_q.push_back(int'(buf_rd_addr));
        if (done_push) done_cnt++;
        if (prev_stall && tx_vld && (tx_data !== prev_data)) stall_bad++;
        prev_stall = tx_vld && !tx_rdy;
        prev_data  = tx_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic fire(input int len);
        fire_push = 1'b1;
        len_push  = (ADDR_W+1)'(len);
        tick();
        fire_push = 1'b0;
    endtask

    task automatic wait_vld(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_sys);
            if (tx_vld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns the cycle (counted from the cycle after fire) holding done_push, or -1.
    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk_sys);
            if (done_push) begin
                cyc = c;
                break;
            end
        end
        tick();
    endtask

    task automatic check_xfer(input string tag, input int n, input int bs, input int br, input int bd);
        logic [7:0] x;
        x = 8'h00;
        chk($sformatf("%s byte_count", tag), sent_q.size() - bs, n + CSUM);
        chk($sformatf("%s read_count", tag), rd_q.size() - br, n);
        chk($sformatf("%s done_count", tag), done_cnt - bd, 1);
        for (int i = 0; i < n; i++) begin
            if (sent_q.size() > bs + i) chk($sformatf("%s data[%0d]", tag, i), sent_q[bs+i], mem[i]);
            if (rd_q.size() > br + i) chk($sformatf("%s addr[%0d]", tag, i), rd_q[br+i], i);
            x ^= mem[i];
        end
`ifdef PUSH_CSUM_EN
        if (sent_q.size() > bs + n) chk($sformatf("%s csum", tag), sent_q[bs+n], x);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bs, br, bd, bb, cyc;
        bit  ok;
        logic exp_vld, exp_done, exp_rd;

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i + 1) * 17);

        // Reset state
        repeat (3) tick();
        chk("rst done_push", done_push, 0);
        chk("rst buf_rd_en", buf_rd_en, 0);
        chk("rst buf_rd_addr", buf_rd_addr, 0);
        chk("rst tx_data", tx_data, 8'h00);
        chk("rst tx_vld", tx_vld, 0);
        rst_n = 1'b1;
        tick();

        // 1: four bytes, tx_rdy high, cycle-exact timing
        tx_rdy = 1'b1;
        bd = done_cnt;
        fire(4);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_sys);
            exp_vld  = ((c % 3 == 0) && (c <= 12)) || ((CSUM == 1) && (c == 13));
            exp_done = (c == 13 + CSUM);
            exp_rd   = (c % 3 == 1) && (c <= 10);
            chk($sformatf("t1 tx_vld c%0d", c), tx_vld, exp_vld);
            chk($sformatf("t1 done c%0d", c), done_push, exp_done);
            chk($sformatf("t1 rd_en c%0d", c), buf_rd_en, exp_rd);
            if (exp_vld) chk($sformatf("t1 tx_data c%0d", c), tx_data, (c <= 12) ? mem[c/3-1] : 8'h44);
        end
        tick();
        chk("t1 done_count", done_cnt - bd, 1);

        // 2: three bytes, 5-cycle stall whenever tx_vld rises
        bs = sent_q.size(); br = rd_q.size(); bd = done_cnt; bb = stall_bad;
        tx_rdy = 1'b0;
        fire(3);
        for (int b = 0; b < 3 + CSUM; b++) begin
            wait_vld(20, ok);
            chk($sformatf("t2 vld_seen[%0d]", b), ok, 1);
            repeat (5) tick();
            tx_rdy = 1'b1;
            tick();
            tx_rdy = 1'b0;
        end
        wait_done(20, cyc);
        chk("t2 done_seen", (cyc > 0), 1);
        chk("t2 stall_stable", stall_bad - bb, 0);
        check_xfer("t2", 3, bs, br, bd);

        // 3: zero length
        tx_rdy = 1'b1;
        bs = sent_q.size(); br = rd_q.size(); bd = done_cnt;
        fire(0);
        wait_done(10, cyc);
        chk("t3 done_cycle", cyc, 1 + CSUM);
        check_xfer("t3", 0, bs, br, bd);

        // 4: second fire during transfer is ignored
        bs = sent_q.size(); br = rd_q.size(); bd = done_cnt;
        fire(5);
        repeat (4) tick();
        fire(9);
        wait_done(60, cyc);
        chk("t4 done_cycle", cyc, 16 + CSUM - 5);
        check_xfer("t4", 5, bs, br, bd);

        // 5: async reset in S_SEND of byte 2 of 8
        bd = done_cnt;
        fire(8);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_sys);
            if (tx_vld && (buf_rd_addr == 1)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5 reached_byte2", ok, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 async done_push", done_push, 0);
        chk("t5 async buf_rd_en", buf_rd_en, 0);
        chk("t5 async buf_rd_addr", buf_rd_addr, 0);
        chk("t5 async tx_data", tx_data, 8'h00);
        chk("t5 async tx_vld", tx_vld, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t5 no_done_on_abort", done_cnt - bd, 0);
        bs = sent_q.size(); br = rd_q.size(); bd = done_cnt;
        fire(2);
        wait_done(20, cyc);
        chk("t5 done_cycle", cyc, 7 + CSUM);
        check_xfer("t5", 2, bs, br, bd);

        // 6: oversize length saturates to 16, addresses 0..15
        bs = sent_q.size(); br = rd_q.size(); bd = done_cnt;
        fire(20);
        wait_done(80, cyc);
        chk("t6 done_cycle", cyc, 49 + CSUM);
        check_xfer("t6", 16, bs, br, bd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
